// File: rtl/dm_pkg.sv
// Shared constants for the data-memory arbiter and region decoder: region map,
// FSM state encoding and the latched-transaction record.
package dm_pkg;

  localparam logic [31:0] STATIC_BEGIN = 32'h0000_0000;
  localparam logic [31:0] STATIC_END   = 32'h0000_07FF;
  localparam logic [31:0] HEAP_BEGIN   = 32'h0000_1000;
  localparam logic [31:0] HEAP_END     = 32'h0000_17FF;
  localparam logic [31:0] STACK_BEGIN  = 32'h0000_2000;
  localparam logic [31:0] STACK_END    = 32'h0000_27FF;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  typedef struct packed {
    logic        port;
    logic        we;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wd;
  } dm_txn_t;

endpackage

// File: rtl/dm_region_decode.sv
// Combinational address decode against the static/heap/stack map; err flags
// misaligned word accesses and addresses that hit no region.
module dm_region_decode
  import dm_pkg::*;
#(
  parameter logic [31:0] P_STATIC_BEGIN = STATIC_BEGIN,
  parameter logic [31:0] P_STATIC_END   = STATIC_END,
  parameter logic [31:0] P_HEAP_BEGIN   = HEAP_BEGIN,
  parameter logic [31:0] P_HEAP_END     = HEAP_END,
  parameter logic [31:0] P_STACK_BEGIN  = STACK_BEGIN,
  parameter logic [31:0] P_STACK_END    = STACK_END
) (
  input  logic [31:0] i_addr,
  output logic        o_hit_static,
  output logic        o_hit_heap,
  output logic        o_hit_stack,
  output logic        o_err
);

  assign o_hit_static = (i_addr >= P_STATIC_BEGIN) && (i_addr <= P_STATIC_END);
  assign o_hit_heap   = (i_addr >= P_HEAP_BEGIN)   && (i_addr <= P_HEAP_END);
  assign o_hit_stack  = (i_addr >= P_STACK_BEGIN)  && (i_addr <= P_STACK_END);
  assign o_err = (i_addr[1:0] != 2'b00) | ~(o_hit_static | o_hit_heap | o_hit_stack);

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin two-port arbiter in front of the single-port data memory.
// Each access runs grant -> access -> response; a new grant may overlap the response.
module dm_arbiter
  import dm_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        p0_req_i,
  input  logic        p0_we_i,
  input  logic [31:0] p0_addr_i,
  input  logic [31:0] p0_wd_i,
  output logic        p0_gnt_o,
  output logic        p0_rvalid_o,
  output logic [31:0] p0_rdata_o,
  output logic        p0_err_o,
  input  logic        p1_req_i,
  input  logic        p1_we_i,
  input  logic [31:0] p1_addr_i,
  input  logic [31:0] p1_wd_i,
  output logic        p1_gnt_o,
  output logic        p1_rvalid_o,
  output logic [31:0] p1_rdata_o,
  output logic        p1_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  output logic        mem_we_o,
  input  logic [31:0] mem_rd_i
);

  logic [1:0]  r_state;
  logic        r_rr_last;
  dm_txn_t     r_txn;
  logic [31:0] r_rdata;

  logic        w_gnt_ok, w_gnt0, w_gnt1, w_access, w_resp;
  logic [31:0] w_req_addr;
  logic        w_hit_static, w_hit_heap, w_hit_stack, w_dec_err, w_err;

  assign w_access = (r_state == S_ACCESS);
  assign w_resp   = (r_state == S_RESP);

  // Gated by rst_i so every output is 0 while reset is held, even with reqs up.
  assign w_gnt_ok = ~rst_i & ((r_state == S_IDLE) | w_resp);
  assign w_gnt0   = w_gnt_ok & p0_req_i & (~p1_req_i | r_rr_last);
  assign w_gnt1   = w_gnt_ok & p1_req_i & (~p0_req_i | ~r_rr_last);
  assign p0_gnt_o = w_gnt0;
  assign p1_gnt_o = w_gnt1;

  assign w_req_addr = w_gnt1 ? p1_addr_i : p0_addr_i;

  dm_region_decode u_decode (
    .i_addr       (w_req_addr),
    .o_hit_static (w_hit_static),
    .o_hit_heap   (w_hit_heap),
    .o_hit_stack  (w_hit_stack),
    .o_err        (w_dec_err)
  );

  assign w_err = w_dec_err | ~(w_hit_static | w_hit_heap | w_hit_stack);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_rr_last <= 1'b1;
      r_txn     <= '0;
      r_rdata   <= '0;
    end else if (w_gnt0 | w_gnt1) begin
      r_txn.port <= w_gnt1;
      r_txn.we   <= w_gnt1 ? p1_we_i : p0_we_i;
      r_txn.err  <= w_err;
      r_txn.addr <= w_req_addr;
      r_txn.wd   <= w_gnt1 ? p1_wd_i : p0_wd_i;
      r_rr_last  <= w_gnt1;
      r_state    <= S_ACCESS;
    end else if (w_access) begin
      r_rdata <= (r_txn.we | r_txn.err) ? 32'h0 : mem_rd_i;
      r_state <= S_RESP;
    end else begin
      r_state <= S_IDLE;
    end
  end

  // Address/data keep showing the last transaction; only the strobe is qualified.
  assign mem_addr_o = r_txn.addr;
  assign mem_wd_o   = r_txn.wd;
  assign mem_we_o   = w_access & r_txn.we & ~r_txn.err;

  assign p0_rvalid_o = w_resp & ~r_txn.port;
  assign p1_rvalid_o = w_resp & r_txn.port;
  assign p0_rdata_o  = p0_rvalid_o ? r_rdata : 32'h0;
  assign p1_rdata_o  = p1_rvalid_o ? r_rdata : 32'h0;
  assign p0_err_o    = p0_rvalid_o & r_txn.err;
  assign p1_err_o    = p1_rvalid_o & r_txn.err;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus randomized traffic checked
// against a cycle-numbered transaction model with its own reference memory.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [31:0] p0_addr = 0, p0_wd = 0, p1_addr = 0, p1_wd = 0;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_we;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] hmem    [0:4095];
  logic [31:0] ref_mem [0:4095];

  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wd_i(p0_wd),
    .p0_gnt_o(p0_gnt), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata), .p0_err_o(p0_err),
    .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wd_i(p1_wd),
    .p1_gnt_o(p1_gnt), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata), .p1_err_o(p1_err),
    .mem_addr_o(mem_addr), .mem_wd_o(mem_wd), .mem_we_o(mem_we), .mem_rd_i(mem_rd)
  );

  // Memory harness: combinational read, write sampled at posedge.
  assign mem_rd = hmem[mem_addr[13:2]];
  always @(posedge clk) if (mem_we) hmem[mem_addr[13:2]] <= mem_wd;

  function automatic bit gnt_of(input int p);     return (p == 0) ? p0_gnt : p1_gnt;       endfunction
  function automatic bit rv_of(input int p);      return (p == 0) ? p0_rvalid : p1_rvalid; endfunction
  function automatic bit err_of(input int p);     return (p == 0) ? p0_err : p1_err;       endfunction
  function automatic logic [31:0] rd_of(input int p); return (p == 0) ? p0_rdata : p1_rdata; endfunction

  function automatic bit ref_err(input logic [31:0] a);
    bit mapped;
    mapped = (a <= 32'h7FF) || (a >= 32'h1000 && a <= 32'h17FF) || (a >= 32'h2000 && a <= 32'h27FF);
    return (a % 4 != 0) || !mapped;
  endfunction

  task automatic drive(input int p, input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin p0_req = req; p0_we = we; p0_addr = a; p0_wd = d; end
    else        begin p1_req = req; p1_we = we; p1_addr = a; p1_wd = d; end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Single-port transaction; records what was observed in cycles N, N+1, N+2.
  task automatic xact(input int p, input bit we, input logic [31:0] a, input logic [31:0] d,
                      output bit gnt_ok, output bit [1:0] we_pat, output logic [31:0] maddr,
                      output bit rv_ok, output bit err, output logic [31:0] rdata);
    bit early;
    gnt_ok = 0; we_pat = 0; maddr = 0; rv_ok = 0; err = 0; rdata = 0;
    @(posedge clk); #1 drive(p, 1, we, a, d);
    for (int i = 0; i < 4 && !gnt_ok; i++) begin
      @(negedge clk);
      if (gnt_of(p)) gnt_ok = 1;
      else begin @(posedge clk); #1; end
    end
    if (!gnt_ok) begin drive(p, 0, 0, 0, 0); return; end
    @(posedge clk); #1 drive(p, 0, 0, 0, 0);
    @(negedge clk); we_pat[1] = mem_we; maddr = mem_addr; early = rv_of(p);
    @(negedge clk); we_pat[0] = mem_we;
    rv_ok = rv_of(p) && !rv_of(1 - p) && !early;
    err = err_of(p); rdata = rd_of(p);
  endtask

  task automatic test_reset();
    @(posedge clk); #1 rst = 1'b1;
    drive(0, 1, 1, 32'h1000, 32'h1); drive(1, 1, 0, 32'h2000, 32'h2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_we, p0_rdata, p1_rdata, mem_addr, mem_wd} !== '0)
        $display("FAIL reset_outputs cyc %0d: gnt %b%b rv %b%b we %b addr %h exp all 0",
                 i, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_we, mem_addr);
      else n_pass++;
    end
    drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_write_read();
    bit g, rv, e; bit [1:0] wp; logic [31:0] ma, rd;
    xact(0, 1, 32'h1004, 32'hDEADBEEF, g, wp, ma, rv, e, rd);
    n_chk++; if (g !== 1'b1) $display("FAIL wr_gnt got %b exp 1", g); else n_pass++;
    n_chk++; if (wp !== 2'b10) $display("FAIL wr_mem_we got %b exp 10", wp); else n_pass++;
    n_chk++; if (ma !== 32'h1004) $display("FAIL wr_mem_addr got %h exp 00001004", ma); else n_pass++;
    n_chk++; if ({rv, e} !== 2'b10) $display("FAIL wr_resp got rv=%b err=%b exp rv=1 err=0", rv, e); else n_pass++;
    xact(1, 0, 32'h1004, 32'h0, g, wp, ma, rv, e, rd);
    n_chk++; if ({g, rv, e, wp} !== 5'b11000) $display("FAIL rd_flags got g=%b rv=%b err=%b we=%b exp 1 1 0 00", g, rv, e, wp); else n_pass++;
    n_chk++; if (rd !== 32'hDEADBEEF) $display("FAIL rd_data got %h exp deadbeef", rd); else n_pass++;
  endtask

  task automatic test_errors();
    bit g, rv, e; bit [1:0] wp; logic [31:0] ma, rd;
    xact(0, 1, 32'h1002, 32'hAAAA5555, g, wp, ma, rv, e, rd);
    n_chk++; if ({g, wp, rv, e, rd} !== {1'b1, 2'b00, 1'b1, 1'b1, 32'h0})
      $display("FAIL err_misaligned got g=%b we=%b rv=%b err=%b rd=%h exp 1 00 1 1 0", g, wp, rv, e, rd); else n_pass++;
    xact(1, 1, 32'h0800, 32'h5555AAAA, g, wp, ma, rv, e, rd);
    n_chk++; if ({g, wp, rv, e, rd} !== {1'b1, 2'b00, 1'b1, 1'b1, 32'h0})
      $display("FAIL err_unmapped got g=%b we=%b rv=%b err=%b rd=%h exp 1 00 1 1 0", g, wp, rv, e, rd); else n_pass++;
    xact(0, 1, 32'h27FC, 32'h12345678, g, wp, ma, rv, e, rd);
    n_chk++; if ({g, wp, rv, e} !== 5'b11010) $display("FAIL stack_top_wr got g=%b we=%b rv=%b err=%b", g, wp, rv, e); else n_pass++;
    xact(1, 0, 32'h27FC, 32'h0, g, wp, ma, rv, e, rd);
    n_chk++; if ({g, rv, e, rd} !== {1'b1, 1'b1, 1'b0, 32'h12345678})
      $display("FAIL stack_top_rd got g=%b rv=%b err=%b rd=%h exp 1 1 0 12345678", g, rv, e, rd); else n_pass++;
    xact(0, 0, 32'h07FC, 32'h0, g, wp, ma, rv, e, rd);
    n_chk++; if ({g, rv, e} !== 3'b110) $display("FAIL static_top_rd got g=%b rv=%b err=%b", g, rv, e); else n_pass++;
  endtask

  task automatic test_round_robin();
    bit [3:0] obs, exp_v;
    do_reset();
    drive(0, 1, 0, 32'h1004, 0); drive(1, 1, 0, 32'h27FC, 0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      exp_v = {k % 4 == 0 && k < 8, k % 4 == 2, k % 4 == 2, k % 4 == 0 && k >= 4};
      obs = {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid};
      n_chk++;
      if (obs !== exp_v) $display("FAIL rr_cyc%0d gnt/rv got %b exp %b", k, obs, exp_v); else n_pass++;
      if (p0_rvalid) begin
        n_chk++; if (p0_rdata !== 32'hDEADBEEF) $display("FAIL rr_p0_rdata got %h exp deadbeef", p0_rdata); else n_pass++;
      end
      if (p1_rvalid) begin
        n_chk++; if (p1_rdata !== 32'h12345678) $display("FAIL rr_p1_rdata got %h exp 12345678", p1_rdata); else n_pass++;
      end
      @(posedge clk); #1;
      if (k == 7) begin drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0); end
    end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_access();
    @(posedge clk); #1 drive(0, 1, 1, 32'h1008, 32'hCAFEF00D);
    @(negedge clk);
    n_chk++; if (p0_gnt !== 1'b1) $display("FAIL rma_gnt got %b exp 1", p0_gnt); else n_pass++;
    @(posedge clk); #1 drive(0, 0, 0, 0, 0);
    #1;
    n_chk++; if (mem_we !== 1'b1) $display("FAIL rma_we_before got %b exp 1", mem_we); else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++; if ({mem_we, mem_addr} !== 33'h0) $display("FAIL rma_we_dropped got we=%b addr=%h exp 0", mem_we, mem_addr); else n_pass++;
    #1 rst = 1'b0;
    @(negedge clk); @(negedge clk);
    n_chk++; if ({p0_rvalid, p1_rvalid} !== 2'b00) $display("FAIL rma_no_rvalid got %b%b exp 00", p0_rvalid, p1_rvalid); else n_pass++;
    n_chk++; if (hmem[32'h1008 >> 2] !== 32'h0) $display("FAIL rma_no_write got %h exp 0", hmem[32'h1008 >> 2]); else n_pass++;
    @(posedge clk); #1 drive(0, 1, 0, 32'h1004, 0); drive(1, 1, 0, 32'h1004, 0);
    @(negedge clk);
    n_chk++; if ({p0_gnt, p1_gnt} !== 2'b10) $display("FAIL rma_first_tie got %b%b exp 10", p0_gnt, p1_gnt); else n_pass++;
    @(posedge clk); #1 drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0);
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_grant_in_resp();
    @(posedge clk); #1 drive(1, 1, 0, 32'h1004, 0);
    @(negedge clk);
    n_chk++; if (p1_gnt !== 1'b1) $display("FAIL gir_p1_gnt got %b exp 1", p1_gnt); else n_pass++;
    @(posedge clk); #1 drive(1, 0, 0, 0, 0);
    @(posedge clk); #1 drive(0, 1, 0, 32'h27FC, 0);
    @(negedge clk);
    n_chk++; if ({p1_rvalid, p0_gnt, p1_rdata} !== {2'b11, 32'hDEADBEEF})
      $display("FAIL gir_overlap got rv1=%b gnt0=%b rd1=%h exp 1 1 deadbeef", p1_rvalid, p0_gnt, p1_rdata); else n_pass++;
    @(posedge clk); #1 drive(0, 0, 0, 0, 0);
    @(negedge clk);
    n_chk++; if (p0_rvalid !== 1'b0) $display("FAIL gir_p0_early got %b exp 0", p0_rvalid); else n_pass++;
    @(negedge clk);
    n_chk++; if ({p0_rvalid, p1_rvalid, p0_rdata} !== {2'b10, 32'h12345678})
      $display("FAIL gir_p0_resp got rv=%b%b rd=%h exp 10 12345678", p0_rvalid, p1_rvalid, p0_rdata); else n_pass++;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] b [0:7];
    b[0] = 32'h7FC; b[1] = 32'h800; b[2] = 32'h17FC; b[3] = 32'h1800;
    b[4] = 32'hFFC; b[5] = 32'h1000; b[6] = 32'h2000; b[7] = 32'h1FFC;
    case ($urandom % 8)
      0, 1, 2, 3, 4:
        case ($urandom % 3)
          0: return ($urandom % 512) * 4;
          1: return 32'h1400 + ($urandom % 256) * 4;
          default: return 32'h2000 + ($urandom % 511) * 4;
        endcase
      5: return 32'h2000 + ($urandom % 511) * 4 + 1 + $urandom % 3;
      6:
        case ($urandom % 3)
          0: return 32'h800 + ($urandom % 512) * 4;
          1: return 32'h1800 + ($urandom % 512) * 4;
          default: return 32'h2800 + ($urandom % 1024) * 4;
        endcase
      default: return b[$urandom % 8];
    endcase
  endfunction

  task automatic test_random();
    bit pend [2];
    bit rwe [2];
    logic [31:0] raddr [2], rwd [2];
    int last_gnt, pref, win, idx;
    bit t_port, t_we, t_err, exp_we, r0, r1;
    logic [31:0] t_addr, t_wd, t_rdata;
    last_gnt = -10; pref = 0; t_port = 0; t_we = 0; t_err = 0; t_addr = 0; t_wd = 0; t_rdata = 0;
    pend[0] = 0; pend[1] = 0; rwe[0] = 0; rwe[1] = 0; raddr[0] = 0; raddr[1] = 0; rwd[0] = 0; rwd[1] = 0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;
    do_reset();
    for (int c = 0; c < 604; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (c >= 600) pend[p] = 0;
        else if (!pend[p] && ($urandom % 3 != 0)) begin
          pend[p] = 1; rwe[p] = $urandom % 2; raddr[p] = rand_addr(); rwd[p] = $urandom;
        end else if (pend[p] && ($urandom % 20 == 0)) pend[p] = 0;
        drive(p, pend[p], rwe[p], raddr[p], rwd[p]);
      end
      @(negedge clk);
      win = -1;
      if (c - last_gnt >= 2) begin
        if (pend[0] && pend[1]) win = pref;
        else if (pend[0]) win = 0;
        else if (pend[1]) win = 1;
      end
      n_chk++;
      if ({p0_gnt, p1_gnt} !== {win == 0, win == 1})
        $display("FAIL rnd_gnt cyc %0d got %b%b exp %b%b", c, p0_gnt, p1_gnt, win == 0, win == 1);
      else n_pass++;
      exp_we = (c == last_gnt + 1) && t_we && !t_err;
      n_chk++;
      if (mem_we !== exp_we) $display("FAIL rnd_mem_we cyc %0d got %b exp %b", c, mem_we, exp_we);
      else n_pass++;
      if (exp_we) begin
        n_chk++;
        if ({mem_addr, mem_wd} !== {t_addr, t_wd})
          $display("FAIL rnd_mem_bus cyc %0d got %h/%h exp %h/%h", c, mem_addr, mem_wd, t_addr, t_wd);
        else n_pass++;
      end
      r0 = (c == last_gnt + 2) && !t_port;
      r1 = (c == last_gnt + 2) && t_port;
      n_chk++;
      if ({p0_rvalid, p1_rvalid} !== {r0, r1})
        $display("FAIL rnd_rvalid cyc %0d got %b%b exp %b%b", c, p0_rvalid, p1_rvalid, r0, r1);
      else n_pass++;
      if (r0 || r1) begin
        n_chk++;
        if ({err_of(int'(t_port)), rd_of(int'(t_port))} !== {t_err, t_rdata})
          $display("FAIL rnd_resp cyc %0d addr %h got err=%b rd=%h exp err=%b rd=%h", c, t_addr,
                   err_of(int'(t_port)), rd_of(int'(t_port)), t_err, t_rdata);
        else n_pass++;
      end
      if (win >= 0) begin
        t_port = (win == 1); t_we = rwe[win]; t_addr = raddr[win]; t_wd = rwd[win];
        t_err = ref_err(t_addr);
        idx = int'(t_addr[13:2]);
        t_rdata = (t_we || t_err) ? 32'h0 : ref_mem[idx];
        if (t_we && !t_err) ref_mem[idx] = t_wd;
        last_gnt = c; pref = 1 - win; pend[win] = 0;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) hmem[i] = 32'h0;
    test_reset();
    test_write_read();
    test_errors();
    test_round_robin();
    test_reset_mid_access();
    test_grant_in_resp();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout after %0d checks", n_chk);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
Two-port arbiter and sequencer in front of the single-port data memory (static/heap/stack regions).
- Shares the memory between port 0 (core load/store unit) and port 1 (loader/debug port) using round-robin.
- Sequences each access through a fixed grant → access → response pipeline.
- Decodes the address against the region map and aborts misaligned or unmapped accesses with an error response, without touching memory.

Parameters:
STATIC_BEGIN, 32'h0000_0000, first byte of static region
STATIC_END, 32'h0000_07FF, last byte of static region
HEAP_BEGIN, 32'h0000_1000, first byte of heap region
HEAP_END, 32'h0000_17FF, last byte of heap region
STACK_BEGIN, 32'h0000_2000, first byte of stack region
STACK_END, 32'h0000_27FF, last byte of stack region

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
p0_req_i  in  1  port 0 request; held with addr/we/wd until p0_gnt_o
p0_we_i  in  1  port 0 write enable (0 = read)
p0_addr_i  in  32  port 0 byte address
p0_wd_i  in  32  port 0 write data
p0_gnt_o  out  1  port 0 request accepted this cycle
p0_rvalid_o  out  1  port 0 response valid, 1-cycle pulse
p0_rdata_o  out  32  port 0 read data, valid with p0_rvalid_o
p0_err_o  out  1  port 0 access error, valid with p0_rvalid_o
p1_*  same set as p0_*, for port 1
mem_addr_o  out  32  memory address
mem_wd_o  out  32  memory write data
mem_we_o  out  1  memory write enable, sampled by memory at posedge
mem_rd_i  in  32  memory read data, combinational from mem_addr_o

Behaviour:
Reset:
- Async assertion forces state IDLE and rr_last = 1, so port 0 wins the first tie.
- All outputs go to 0 immediately, including mem_we_o. This also applies mid-operation: an in-flight write is aborted, and a pending response is dropped (no rvalid).

FSM states:
- IDLE: no transaction in flight.
- ACCESS: the latched transaction drives the memory bus.
- RESP: the response is presented to the winning port.

Arbitration:
- Grants are issued only in IDLE or RESP.
- If exactly one req is high, that port wins. If both are high, the port != rr_last wins.
- gnt_o is combinational from req in the grant cycle.
- On grant, latch port id, we, addr, wd, and the decode result; update rr_last; go to ACCESS.
- With no grant, RESP→IDLE and IDLE→IDLE.

ACCESS (always 1 cycle):
- mem_addr_o = latched addr; mem_wd_o = latched wd; mem_we_o = latched we & ~err.
- Capture mem_rd_i into the rdata register (0 on error or write).
- Next state is RESP.

RESP:
- Assert rvalid_o, rdata_o, and err_o on the latched port only; the other port's outputs stay 0.
- A new grant in the same cycle is allowed, so back-to-back throughput is 1 access per 2 cycles.
- Latency: grant cycle N, memory access N+1, rvalid N+2.

Memory bus outside ACCESS:
- mem_we_o = 0; mem_addr_o and mem_wd_o hold their last values.

Error (err) conditions:
- addr[1:0] != 0, or
- addr outside all three inclusive [BEGIN, END] ranges.
- An errored write never asserts mem_we_o; an errored read returns rdata = 0.

Requester contract:
- req/addr/we/wd stay stable until gnt. A requester may re-request in the cycle after gnt.
- A req dropped before gnt is legal and simply not served.

Decomposition:
- Shared defines/package dm_pkg: region BEGIN/END constants (defaults above) and FSM state encoding (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2).
- One sub-module, dm_region_decode: combinational, addr → hit_static/hit_heap/hit_stack/err; reused by the data memory itself.

Test Plan:
1. Write 32'hDEADBEEF to 32'h0000_1004 via p0 → p0_gnt_o in cycle N; mem_we_o = 1 with mem_addr_o = 32'h1004 in N+1 only; p0_rvalid_o = 1, p0_err_o = 0 in N+2.
2. Read back 32'h1004 via p1 with memory model returning 32'hDEADBEEF → p1_rvalid_o in N+2 with p1_rdata_o = 32'hDEADBEEF; p0 outputs stay 0.
3. Both ports request continuously after reset → grant order p0, p1, p0, p1; grants 2 cycles apart; each rvalid lands on the port granted 2 cycles earlier.
4. Write to 32'h0000_1002 (misaligned) and to 32'h0000_0800 (unmapped) → mem_we_o never asserted; rvalid with err_o = 1, rdata_o = 0. Read at 32'h0000_27FC succeeds, err = 0.
5. Assert rst_i asynchronously during the ACCESS cycle of a write → mem_we_o drops to 0 before the edge; no rvalid follows. After release, simultaneous reqs grant p0 first.
6. p0 requests alone in the RESP cycle of a p1 read → p0_gnt_o in that same cycle, p1_rvalid_o also high; p0 response follows 2 cycles later.
